copter_cmd_responder: RTL and testbench

- Copter-side end of the wireless command link; counterpart of the ground-side master that sends a command plus data and waits for a response.
- Receives a 3-byte frame over UART 8N1: cmd, then data[15:8], then data[7:0].
- Presents the frame as cmd/data with a ready flag to the command-configuration logic.
- Serializes the one-byte response from that logic (POS_ACK 0xA5, battery reading, ...) back over TX.

---
 rtl/copter_cmd_responder.sv | 164 ++++++++++++++++
 tb/tb_copter_cmd_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copter_cmd_responder.sv
// copter_cmd_responder: UART 8N1 receiver for 3-byte cmd frames and a 1-byte response transmitter.
// Define FRAME_TIMEOUT_EN to abandon partial frames after about 12 idle byte-times.
module copter_cmd_responder #(
  parameter int BAUD_DIV = 2604,
  parameter int FRAME_BYTES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RX,
  output logic                           TX,
  output logic [7:0]                     cmd,
  output logic [8*(FRAME_BYTES-1)-1:0]   data,
  output logic                           cmd_rdy,
  input  logic                           clr_cmd_rdy,
  input  logic [7:0]                     resp,
  input  logic                           send_resp,
  output logic                           resp_sent,
  output logic                           tx_busy,
  output logic                           frame_err
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] FULL = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} asm_t;
  ser_t rs, ts;
  asm_t as;
  logic rx_s1, rx_s2, rx_prev;
  logic [BW-1:0] rcnt, tcnt;
  logic [3:0] rbits, tbits;
  logic [7:0] rsh, tsh, sh_cmd, sh_hi;
  logic stop_smp, byte_ok, byte_bad, to_hit;
  assign stop_smp = rs == S_STOP && rcnt == '0;
  assign byte_ok = stop_smp && rx_s2;
  assign byte_bad = stop_smp && !rx_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      rs <= S_IDLE;
      rcnt <= '0;
      rbits <= '0;
      rsh <= '0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      case (rs)
        S_IDLE: if (rx_prev && !rx_s2) begin
          rs <= S_START;
          rcnt <= HALF;
        end
        S_START: if (rcnt != '0) rcnt <= rcnt - 1'b1;
        else if (rx_s2) rs <= S_IDLE;
        else begin
          rs <= S_DATA;
          rcnt <= FULL;
          rbits <= '0;
        end
        S_DATA: if (rcnt != '0) rcnt <= rcnt - 1'b1;
        else begin
          rsh <= {rx_s2, rsh[7:1]};
          rcnt <= FULL;
          if (rbits == 4'd7) rs <= S_STOP;
          else rbits <= rbits + 1'b1;
        end
        default: if (rcnt != '0) rcnt <= rcnt - 1'b1;
        else rs <= S_IDLE;
      endcase
    end
  end
  // completion is evaluated before the clear so a coincident clr_cmd_rdy loses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as <= WAIT_CMD;
      {sh_cmd, sh_hi, cmd} <= '0;
      data <= '0;
      cmd_rdy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= byte_bad | to_hit;
      cmd_rdy <= (byte_ok && as == WAIT_LO) | (cmd_rdy & ~clr_cmd_rdy);
      if (byte_bad || to_hit) begin
        as <= WAIT_CMD;
        sh_cmd <= '0;
        sh_hi <= '0;
      end else if (byte_ok) begin
        case (as)
          WAIT_CMD: begin
            sh_cmd <= rsh;
            as <= WAIT_HI;
          end
          WAIT_HI: begin
            sh_hi <= rsh;
            as <= WAIT_LO;
          end
          default: begin
            cmd <= sh_cmd;
            data <= {sh_hi, rsh};
            as <= WAIT_CMD;
          end
        endcase
      end
    end
  end
`ifdef FRAME_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(12 * 10 * BAUD_DIV - 1);
  logic [19:0] idle_cnt;
  assign to_hit = as != WAIT_CMD && !byte_ok && idle_cnt == TO_LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else idle_cnt <= (as == WAIT_CMD || byte_ok || to_hit) ? '0 : idle_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= S_IDLE;
      TX <= 1'b1;
      tx_busy <= 1'b0;
      resp_sent <= 1'b0;
      tcnt <= '0;
      tbits <= '0;
      tsh <= '0;
    end else begin
      resp_sent <= 1'b0;
      case (ts)
        S_IDLE: if (send_resp) begin
          tsh <= resp;
          TX <= 1'b0;
          tx_busy <= 1'b1;
          tcnt <= FULL;
          ts <= S_START;
        end
        S_START: if (tcnt != '0) tcnt <= tcnt - 1'b1;
        else begin
          TX <= tsh[0];
          tsh <= {1'b1, tsh[7:1]};
          tcnt <= FULL;
          tbits <= '0;
          ts <= S_DATA;
        end
        S_DATA: if (tcnt != '0) tcnt <= tcnt - 1'b1;
        else begin
          tcnt <= FULL;
          if (tbits == 4'd7) begin
            TX <= 1'b1;
            ts <= S_STOP;
          end else begin
            TX <= tsh[0];
            tsh <= {1'b1, tsh[7:1]};
            tbits <= tbits + 1'b1;
          end
        end
        default: if (tcnt != '0) tcnt <= tcnt - 1'b1;
        else begin
          resp_sent <= 1'b1;
          tx_busy <= 1'b0;
          ts <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_copter_cmd_responder.sv
// tb_copter_cmd_responder: randomized UART frame/response bench with a frame-level reference model.
module tb_copter_cmd_responder;
  localparam int BD = 16;
  logic clk = 0, rst = 1, RX = 1, clr_cmd_rdy = 0, send_resp = 0;
  logic [7:0] resp = 0;
  logic TX, cmd_rdy, resp_sent, tx_busy, frame_err;
  logic [7:0] cmd;
  logic [15:0] data;
  int n_chk = 0, n_fail = 0, fe_cnt = 0, rs_cnt = 0, rdy_cnt = 0;
  logic [7:0] exp_cmd = 0;
  logic [15:0] exp_data = 0;
  logic exp_rdy = 0;

  copter_cmd_responder #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (resp_sent) rs_cnt++;
    if (cmd_rdy) rdy_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stop;
    tick(BD);
    RX = 1;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2);
    send_byte(b0, 1);
    send_byte(b1, 1);
    send_byte(b2, 1);
    exp_cmd = b0;
    exp_data = {b1, b2};
    exp_rdy = 1;
  endtask

  task automatic tx_start(input logic [7:0] b);
    resp = b;
    send_resp = 1;
    tick(1);
    send_resp = 0;
  endtask

  task automatic tx_watch(input logic [7:0] b, input int ign, input bit chain, input logic [7:0] cb);
    logic [9:0] fr;
    logic exp_tx;
    fr = {1'b1, b, 1'b0};
    for (int c = 0; c <= 160; c++) begin
      exp_tx = (c < 160) ? fr[c / 16] : 1'b1;
      n_chk++;
      if (TX !== exp_tx) begin
        n_fail++;
        $display("FAIL tx_bit c=%0d: TX=%b expected %b (byte %h)", c, TX, exp_tx, b);
      end
      n_chk++;
      if ({tx_busy, resp_sent} !== ((c < 160) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL tx_flags c=%0d: busy,sent=%b%b expected %b", c, tx_busy, resp_sent, (c < 160) ? 2'b10 : 2'b01);
      end
      send_resp = 0;
      if (c == ign) begin
        resp = 8'h3C;
        send_resp = 1;
      end
      if (c == 160 && chain) begin
        resp = cb;
        send_resp = 1;
      end
      tick(1);
    end
    send_resp = 0;
    if (!chain) for (int c = 0; c < 16; c++) begin
      n_chk++;
      if ({TX, tx_busy, resp_sent} !== 3'b100) begin
        n_fail++;
        $display("FAIL tx_idle c=%0d: TX,busy,sent=%b expected 100", c, {TX, tx_busy, resp_sent});
      end
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    tick(3);
    n_chk++;
    if ({TX, cmd, data, cmd_rdy, resp_sent, tx_busy, frame_err} !== {1'b1, 24'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset: TX=%b cmd=%h data=%h rdy=%b sent=%b busy=%b ferr=%b expected TX=1 rest 0",
               TX, cmd, data, cmd_rdy, resp_sent, tx_busy, frame_err);
    end
    rst = 0;
    tick(2);
  endtask

  task automatic test_first_frame;
    send_byte(8'h05, 1);
    send_byte(8'h00, 1);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== 25'h0) begin
      n_fail++;
      $display("FAIL partial_frame: cmd=%h data=%h rdy=%b expected 00 0000 0", cmd, data, cmd_rdy);
    end
    send_byte(8'h50, 1);
    exp_cmd = 8'h05; exp_data = 16'h0050; exp_rdy = 1;
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {exp_cmd, exp_data, exp_rdy}) begin
      n_fail++;
      $display("FAIL first_frame: cmd=%h data=%h rdy=%b expected %h %h %b", cmd, data, cmd_rdy, exp_cmd, exp_data, exp_rdy);
    end
  endtask

  task automatic test_overwrite;
    send_frame(8'h02, 8'h00, 8'h90);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {8'h02, 16'h0090, 1'b1}) begin
      n_fail++;
      $display("FAIL overwrite: cmd=%h data=%h rdy=%b expected 02 0090 1", cmd, data, cmd_rdy);
    end
    clr_cmd_rdy = 1;
    tick(1);
    clr_cmd_rdy = 0;
    exp_rdy = 0;
    tick(1);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {exp_cmd, exp_data, exp_rdy}) begin
      n_fail++;
      $display("FAIL clear: cmd=%h data=%h rdy=%b expected %h %h 0", cmd, data, cmd_rdy, exp_cmd, exp_data);
    end
  endtask

  task automatic test_random_frames;
    logic [7:0] b0, b1, b2;
    int mode;
    for (int k = 0; k < 6; k++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        clr_cmd_rdy = 1;
        tick(1);
        clr_cmd_rdy = 0;
        exp_rdy = 0;
        tick(1);
        n_chk++;
        if (cmd_rdy !== exp_rdy) begin
          n_fail++;
          $display("FAIL rand_clear k=%0d: rdy=%b expected 0", k, cmd_rdy);
        end
      end
      send_byte(b0, 1);
      tick($urandom_range(0, 20));
      send_byte(b1, 1);
      tick($urandom_range(0, 20));
      if (mode == 2) begin
        clr_cmd_rdy = 1;
        tick(2);
        rdy_cnt = 0;
        send_byte(b2, 1);
        clr_cmd_rdy = 0;
        exp_cmd = b0; exp_data = {b1, b2}; exp_rdy = 0;
        n_chk++;
        if (rdy_cnt !== 1) begin
          n_fail++;
          $display("FAIL clr_collision k=%0d: cmd_rdy high %0d cycles expected 1", k, rdy_cnt);
        end
      end else begin
        send_byte(b2, 1);
        exp_cmd = b0; exp_data = {b1, b2}; exp_rdy = 1;
      end
      n_chk++;
      if ({cmd, data, cmd_rdy} !== {exp_cmd, exp_data, exp_rdy}) begin
        n_fail++;
        $display("FAIL rand_frame k=%0d mode=%0d: cmd=%h data=%h rdy=%b expected %h %h %b",
                 k, mode, cmd, data, cmd_rdy, exp_cmd, exp_data, exp_rdy);
      end
    end
  endtask

  task automatic test_tx;
    int rs0;
    logic [7:0] r;
    rs0 = rs_cnt;
    tx_start(8'hA5);
    tx_watch(8'hA5, 40, 0, 8'h00);
    r = 8'($urandom);
    tx_start(r);
    tx_watch(r, -1, 0, 8'h00);
    n_chk++;
    if (rs_cnt !== rs0 + 2) begin
      n_fail++;
      $display("FAIL resp_sent_count: got %0d expected %0d", rs_cnt - rs0, 2);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r1, r2;
    int rs0;
    rs0 = rs_cnt;
    r1 = 8'($urandom); r2 = 8'($urandom);
    tx_start(r1);
    tx_watch(r1, -1, 1, r2);
    tx_watch(r2, -1, 0, 8'h00);
    n_chk++;
    if (rs_cnt !== rs0 + 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected %0d", rs_cnt - rs0, 2);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h11, 1);
    send_byte(8'h06, 0);
    tick(BD);
    n_chk++;
    if (fe_cnt !== fe0 + 1) begin
      n_fail++;
      $display("FAIL frame_err_pulse: got %0d expected %0d", fe_cnt - fe0, 1);
    end
    send_frame(8'h06, 8'h87, 8'h89);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {8'h06, 16'h8789, 1'b1}) begin
      n_fail++;
      $display("FAIL after_err_frame: cmd=%h data=%h rdy=%b expected 06 8789 1", cmd, data, cmd_rdy);
    end
    n_chk++;
    if (fe_cnt !== fe0 + 1) begin
      n_fail++;
      $display("FAIL spurious_frame_err: got %0d expected %0d", fe_cnt - fe0, 1);
    end
  endtask

  task automatic test_full_duplex;
    logic [7:0] r, b0, b1, b2;
    r = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    fork
      begin
        tx_start(r);
        tx_watch(r, -1, 0, 8'h00);
      end
      send_frame(b0, b1, b2);
    join
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {exp_cmd, exp_data, exp_rdy}) begin
      n_fail++;
      $display("FAIL duplex_frame: cmd=%h data=%h rdy=%b expected %h %h %b", cmd, data, cmd_rdy, exp_cmd, exp_data, exp_rdy);
    end
  endtask

  task automatic test_rst_mid;
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 1);
    tx_start(8'($urandom));
    tick(8);
    #3 rst = 1;
    #1;
    n_chk++;
    if ({TX, cmd_rdy, tx_busy, cmd, data} !== {3'b100, 24'h0}) begin
      n_fail++;
      $display("FAIL async_reset: TX=%b rdy=%b busy=%b cmd=%h data=%h expected 1 0 0 00 0000", TX, cmd_rdy, tx_busy, cmd, data);
    end
    tick(2);
    rst = 0;
    exp_cmd = 0; exp_data = 0; exp_rdy = 0;
    tick(2);
    send_frame(8'h01, 8'h00, 8'h00);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {8'h01, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_frame: cmd=%h data=%h rdy=%b expected 01 0000 1", cmd, data, cmd_rdy);
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout;
    int fe0;
    clr_cmd_rdy = 1;
    tick(1);
    clr_cmd_rdy = 0;
    fe0 = fe_cnt;
    send_byte(8'($urandom), 1);
    tick(12 * 10 * BD + 20);
    n_chk++;
    if (fe_cnt !== fe0 + 1 || cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: frame_err pulses=%0d rdy=%b expected 1 0", fe_cnt - fe0, cmd_rdy);
    end
    send_frame(8'h07, 8'h12, 8'h34);
    n_chk++;
    if ({cmd, data, cmd_rdy} !== {8'h07, 16'h1234, 1'b1}) begin
      n_fail++;
      $display("FAIL after_timeout: cmd=%h data=%h rdy=%b expected 07 1234 1", cmd, data, cmd_rdy);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_first_frame;
    test_overwrite;
    test_random_frames;
    test_tx;
    test_back_to_back;
    test_frame_err;
    test_full_duplex;
    test_rst_mid;
`ifdef FRAME_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
